// File: rtl/num_board_adjacent.sv
// num_board_adjacent: minesweeper number board, one saturating adjacent-mine count per cell.
// Each accepted increment request walks the eight neighbours of a centre cell, one
// read-modify-write per cycle, with a registered read port for display/reveal logic.
// Optional feature macro: NUM_BOARD_PENDING_EN adds a one-entry pending request register.
module num_board_adjacent #(
  parameter int unsigned COLS = 16,
  parameter int unsigned ROWS = 16,
  parameter int unsigned XW   = 4,
  parameter int unsigned YW   = 4,
  parameter int unsigned CW   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc_req,
  input  logic [XW-1:0] inc_x,
  input  logic [YW-1:0] inc_y,
  output logic          inc_busy,
  output logic          inc_done,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [CW-1:0] rd_count
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int unsigned AW    = (NCELL > 1) ? $clog2(NCELL) : 1;

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic          done_q, done_d;

  logic [CW-1:0] cnt [NCELL];

  int            dxi, dyi, nxi, nyi;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_ok;
  logic [AW-1:0] rd_addr;

`ifdef NUM_BOARD_PENDING_EN
  logic          pend_v_q, pend_v_d;
  logic [XW-1:0] pend_x_q, pend_x_d;
  logic [YW-1:0] pend_y_q, pend_y_d;

  assign inc_busy = pend_v_q;
`else
  assign inc_busy = (state_q != StIdle);
`endif

  assign inc_done = done_q;

  // Neighbour offset for the current walk index, in the fixed row-major order.
  always_comb begin
    dxi = 0;
    dyi = 0;
    unique case (idx_q)
      3'd0: begin dxi = -1; dyi = -1; end
      3'd1: begin dxi =  0; dyi = -1; end
      3'd2: begin dxi =  1; dyi = -1; end
      3'd3: begin dxi = -1; dyi =  0; end
      3'd4: begin dxi =  1; dyi =  0; end
      3'd5: begin dxi = -1; dyi =  1; end
      3'd6: begin dxi =  0; dyi =  1; end
      3'd7: begin dxi =  1; dyi =  1; end
    endcase
  end

  // Neighbour address and range check; off-board neighbours still burn their cycle.
  always_comb begin
    nxi     = int'(cx_q) + dxi;
    nyi     = int'(cy_q) + dyi;
    wr_en   = (state_q == StWalk) && !clear && (nxi >= 0) && (nxi < int'(COLS)) &&
              (nyi >= 0) && (nyi < int'(ROWS));
    wr_addr = AW'(nyi * int'(COLS) + nxi);
    rd_ok   = (int'(rd_x) < int'(COLS)) && (int'(rd_y) < int'(ROWS));
    rd_addr = AW'(int'(rd_y) * int'(COLS) + int'(rd_x));
  end

  // Walk state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
    end
  end

`ifdef NUM_BOARD_PENDING_EN
  // Pending request register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_v_q <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
    end else begin
      pend_v_q <= pend_v_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
    end
  end
`endif

  // Next-state logic; clear overrides everything, including a same-cycle request.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    done_d  = 1'b0;
`ifdef NUM_BOARD_PENDING_EN
    pend_v_d = pend_v_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
`endif
    if (clear) begin
      state_d = StIdle;
      idx_d   = '0;
`ifdef NUM_BOARD_PENDING_EN
      pend_v_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (inc_req) begin
            cx_d    = inc_x;
            cy_d    = inc_y;
            idx_d   = '0;
            state_d = StWalk;
          end
        end
        StWalk: begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = StDone;
`ifdef NUM_BOARD_PENDING_EN
          if (inc_req && !pend_v_q) begin
            pend_v_d = 1'b1;
            pend_x_d = inc_x;
            pend_y_d = inc_y;
          end
`endif
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef NUM_BOARD_PENDING_EN
          // Chain straight into the next walk so back-to-back requests skip IDLE.
          if (pend_v_q) begin
            cx_d     = pend_x_q;
            cy_d     = pend_y_q;
            idx_d    = '0;
            pend_v_d = 1'b0;
            state_d  = StWalk;
          end else if (inc_req) begin
            cx_d    = inc_x;
            cy_d    = inc_y;
            idx_d   = '0;
            state_d = StWalk;
          end
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Count storage: saturating increment of one neighbour per walk cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NCELL); i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(NCELL); i++) cnt[i] <= '0;
    end else if (wr_en) begin
      if (cnt[wr_addr] != {CW{1'b1}}) cnt[wr_addr] <= cnt[wr_addr] + 1'b1;
    end
  end

  // Registered read port; same-cycle writes are seen on the following read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
    end else begin
      rd_count <= rd_ok ? cnt[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_num_board_adjacent.sv
// Randomized self-checking bench for num_board_adjacent against a whole-request board model.
module tb_num_board_adjacent;

  localparam int COLS = 12;
  localparam int ROWS = 10;
  localparam int XW   = 4;
  localparam int YW   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          inc_req;
  logic [XW-1:0] inc_x;
  logic [YW-1:0] inc_y;
  logic          inc_busy;
  logic          inc_done;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic [CW-1:0] rd_count;

  int n_checks = 0;
  int n_pass   = 0;
  int model [COLS][ROWS];

  num_board_adjacent #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .CW(CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .inc_req  (inc_req),
    .inc_x    (inc_x),
    .inc_y    (inc_y),
    .inc_busy (inc_busy),
    .inc_done (inc_done),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a request adds one (saturating) to every on-board cell around the centre.
  function automatic void model_apply(input int x, input int y);
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < COLS &&
            y + dy >= 0 && y + dy < ROWS && model[x + dx][y + dy] < CMAX)
          model[x + dx][y + dy]++;
      end
    end
  endfunction

  function automatic void model_clear();
    for (int x = 0; x < COLS; x++) for (int y = 0; y < ROWS; y++) model[x][y] = 0;
  endfunction

  function automatic int model_at(input int x, input int y);
    if (x >= COLS || y >= ROWS) return 0;
    return model[x][y];
  endfunction

  task automatic rd(input int x, input int y, output int v);
    rd_x = XW'(x);
    rd_y = YW'(y);
    tick();
    v = int'(rd_count);
  endtask

  task automatic check_board(input string tag);
    int v;
    for (int x = 0; x < COLS; x++) begin
      for (int y = 0; y < ROWS; y++) begin
        rd(x, y, v);
        check_eq($sformatf("%s(%0d,%0d)", tag, x, y), v, model[x][y]);
      end
    end
  endtask

  // Count ticks until inc_done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (inc_done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Issue one request from IDLE, check latency and pulse width, update the model.
  task automatic do_req(input int x, input int y, input string tag);
    int lat;
    inc_x   = XW'(x);
    inc_y   = YW'(y);
    inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    wait_done(lat);
    check_eq({tag, "_lat"}, lat, 9);
    tick();
    check_eq({tag, "_pulse"}, int'(inc_done), 0);
    model_apply(x, y);
  endtask

  initial begin
    int v, n, pulses;
    reset = 1'b1; clear = 1'b0; inc_req = 1'b0; inc_x = '0; inc_y = '0; rd_x = '0; rd_y = '0;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_busy", int'(inc_busy), 0);
    check_eq("rst_done", int'(inc_done), 0);
    check_eq("rst_rd", int'(rd_count), 0);

    // Corner mine, with busy following acceptance
    inc_x = '0; inc_y = '0; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
`ifdef NUM_BOARD_PENDING_EN
    check_eq("corner_busy", int'(inc_busy), 0);
`else
    check_eq("corner_busy", int'(inc_busy), 1);
`endif
    wait_done(n);
    check_eq("corner_lat", n, 9);
    tick();
    check_eq("corner_pulse", int'(inc_done), 0);
    model_apply(0, 0);
    rd(1, 1, v); check_eq("corner_11", v, 1);
    check_board("corner");

    // Interior pair
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    do_req(5, 5, "pair_a");
    do_req(6, 5, "pair_b");
    rd(6, 4, v); check_eq("pair_64", v, 2);
    rd(8, 5, v); check_eq("pair_85", v, 0);
    check_board("pair");

    // Saturation
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    for (int i = 0; i < 16; i++) do_req(3, 3, "sat");
    rd(2, 2, v); check_eq("sat_22", v, 15);
    rd(4, 4, v); check_eq("sat_44", v, 15);
    check_board("sat");

    // Abort by clear at the 4th walk cycle, then a normal request
    inc_x = 4'd5; inc_y = 4'd5; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    repeat (3) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    model_clear();
    check_eq("abort_busy", int'(inc_busy), 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (inc_done) pulses++;
      tick();
    end
    check_eq("abort_nodone", pulses, 0);
    check_board("abort");
    do_req(2, 3, "after_abort");

    // Request coinciding with clear is ignored
    inc_x = 4'd4; inc_y = 4'd4; inc_req = 1'b1; clear = 1'b1;
    tick();
    inc_req = 1'b0; clear = 1'b0; model_clear();
    check_eq("clr_req_busy", int'(inc_busy), 0);
    repeat (12) tick();
    check_board("clr_req");

    // Second request two cycles after acceptance
    inc_x = 4'd1; inc_y = 4'd1; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    tick();
    inc_x = 4'd9; inc_y = 4'd9; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    check_eq("drop_busy", int'(inc_busy), 1);
    wait_done(n);
    check_eq("drop_lat1", n, 7);
    model_apply(1, 1);
    tick();
`ifdef NUM_BOARD_PENDING_EN
    n = 1;
    while (inc_done !== 1'b1 && n < 40) begin tick(); n++; end
    check_eq("pend_gap", n, 9);
    model_apply(9, 9);
    tick();
`else
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (inc_done) pulses++;
      tick();
    end
    check_eq("drop_nodone", pulses, 0);
`endif
    check_board("drop");

    // Randomized requests, including off-board centres
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    for (int i = 0; i < 40; i++) do_req($urandom_range(0, 15), $urandom_range(0, 15), "rnd");
    check_board("rnd");
    for (int i = 0; i < 20; i++) begin
      int x, y;
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      rd(x, y, v);
      check_eq($sformatf("rnd_rd(%0d,%0d)", x, y), v, model_at(x, y));
    end
    rd(COLS, 0, v); check_eq("rd_oob", v, 0);

    // Asynchronous reset in mid-walk
    inc_x = 4'd6; inc_y = 4'd6; inc_req = 1'b1;
    tick();
    inc_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_eq("areset_busy", int'(inc_busy), 0);
    check_eq("areset_rd", int'(rd_count), 0);
    tick();
    reset = 1'b0;
    model_clear();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (inc_done) pulses++;
      tick();
    end
    check_eq("areset_nodone", pulses, 0);
    check_board("areset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
